// File: rtl/window_rotate_scheduler.sv
// ============================================================================
//  Module   : window_rotate_scheduler
//  Purpose  : Issue controller for the 9-instance rotated-window sampler bank
//             (0..80 deg in 10 deg steps). Orientation bins (0..35, 10 deg
//             each) are split into quadrant (bin/9) and sub-angle (bin%9).
//             The sub-angle drives the bank's one-hot select. A shadow
//             pipeline carries each request's quadrant and tag alongside the
//             bank, so both arrive at the output together with the window.
//  Ports    : clk, rst_n               clock, async active-low reset
//             req_valid/ready/angle/tag request handshake (bin + opaque tag)
//             rot_en, rot_sel, rot_quad bank enable, one-hot select, quadrant
//             out_valid/ready/quad/tag  output window handshake + alignment
//             busy                      any entry in flight or sweep active
//             err_angle                 sticky: an out-of-range bin accepted
//             sweep_start, sweep_done   (WROT_SWEEP_EN only) self-test sweep
//  Config   : define WROT_SWEEP_EN to add the 0..35 sweep FSM and its ports.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_rotate_scheduler #(
  parameter int PIPE_LAT = 2,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_angle,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rot_en,
  output logic [8:0]       rot_sel,
  output logic [1:0]       rot_quad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_quad,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
`ifdef WROT_SWEEP_EN
  input  logic             sweep_start,
  output logic             sweep_done,
`endif
  output logic             err_angle
);

  localparam logic [5:0] NUM_BINS = 6'd36;
  localparam logic [5:0] LAST_BIN = 6'd35;

  // Returns {quad, one-hot sel}. Out-of-range bins fall through to bin 0.
  function automatic logic [10:0] decode_bin(input logic [5:0] bin);
    logic [10:0] r;
    r = {2'd0, 9'd1};
    for (int q = 0; q < 4; q++) begin
      for (int s = 0; s < 9; s++) begin
        if (bin == 6'(q * 9 + s)) r = {2'(q), 9'(1) << s};
      end
    end
    return r;
  endfunction

  // Shadow pipeline state; index PIPE_LAT-1 is the output stage.
  logic [PIPE_LAT-1:0] vld_q;
  logic [1:0]          quad_q [PIPE_LAT];
  logic [TAG_W-1:0]    tag_q  [PIPE_LAT];

  logic [8:0]          rot_sel_q;
  logic [1:0]          rot_quad_q;
  logic                err_q;

  logic                issue;
  logic [5:0]          issue_bin;
  logic [TAG_W-1:0]    issue_tag;
  logic [10:0]         dec;
  logic                bin_illegal;
  logic                sweep_active;

  // A held output that is not being taken freezes the bank and the shadow pipe.
  assign rot_en = !(vld_q[PIPE_LAT-1] && !out_ready);

`ifdef WROT_SWEEP_EN
  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_DRAIN = 2'd2
  } sweep_state_e;

  sweep_state_e state_q;
  logic [5:0]   cnt_q;
  logic         done_q;

  // sweep_start takes priority over a simultaneous request.
  assign req_ready    = rot_en && (state_q == SW_IDLE) && !sweep_start;
  assign sweep_active = (state_q != SW_IDLE);
  assign sweep_done   = done_q;

  always_comb begin
    issue     = req_valid && req_ready;
    issue_bin = req_angle;
    issue_tag = req_tag;
    if (state_q == SW_RUN && rot_en) begin
      issue     = 1'b1;
      issue_bin = cnt_q;
      issue_tag = TAG_W'(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SW_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SW_IDLE: begin
          if (sweep_start && rot_en) begin
            state_q <= SW_RUN;
            cnt_q   <= '0;
          end
        end
        SW_RUN: begin
          // Counter advances only on cycles where the bin was actually issued.
          if (rot_en) begin
            if (cnt_q == LAST_BIN) state_q <= SW_DRAIN;
            else                   cnt_q   <= cnt_q + 6'd1;
          end
        end
        SW_DRAIN: begin
          // vld_q includes the output stage, so this waits for the last consume.
          if (!(|vld_q)) begin
            state_q <= SW_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= SW_IDLE;
      endcase
    end
  end
`else
  assign req_ready    = rot_en;
  assign sweep_active = 1'b0;

  always_comb begin
    issue     = req_valid && req_ready;
    issue_bin = req_angle;
    issue_tag = req_tag;
  end
`endif

  assign dec         = decode_bin(issue_bin);
  assign bin_illegal = (issue_bin >= NUM_BINS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_sel_q  <= 9'h001;
      rot_quad_q <= '0;
      err_q      <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        quad_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      // Issue implies rot_en; without an issue the select keeps its last one-hot value.
      if (issue) begin
        rot_sel_q  <= dec[8:0];
        rot_quad_q <= dec[10:9];
      end
      if (issue && bin_illegal) err_q <= 1'b1;
      if (rot_en) begin
        vld_q[0]  <= issue;
        quad_q[0] <= dec[10:9];
        tag_q[0]  <= issue_tag;
        for (int i = 1; i < PIPE_LAT; i++) begin
          vld_q[i]  <= vld_q[i-1];
          quad_q[i] <= quad_q[i-1];
          tag_q[i]  <= tag_q[i-1];
        end
      end
    end
  end

  assign rot_sel   = rot_sel_q;
  assign rot_quad  = rot_quad_q;
  assign err_angle = err_q;
  assign out_valid = vld_q[PIPE_LAT-1];
  assign out_quad  = quad_q[PIPE_LAT-1];
  assign out_tag   = tag_q[PIPE_LAT-1];
  assign busy      = (|vld_q) || sweep_active;

endmodule

`default_nettype wire

// File: tb/tb_window_rotate_scheduler.sv
`timescale 1ns/1ps
`default_nettype none

module tb_window_rotate_scheduler;

  localparam int PIPE_LAT = 2;
  localparam int TAG_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [5:0]       req_angle = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             out_ready = 1'b0;
  logic             req_ready, rot_en, out_valid, busy, err_angle;
  logic [8:0]       rot_sel;
  logic [1:0]       rot_quad, out_quad;
  logic [TAG_W-1:0] out_tag;
`ifdef WROT_SWEEP_EN
  logic             sweep_start = 1'b0;
  logic             sweep_done;
`endif

  window_rotate_scheduler #(.PIPE_LAT(PIPE_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle), .req_tag(req_tag),
    .rot_en(rot_en), .rot_sel(rot_sel), .rot_quad(rot_quad),
    .out_valid(out_valid), .out_ready(out_ready), .out_quad(out_quad), .out_tag(out_tag),
    .busy(busy),
`ifdef WROT_SWEEP_EN
    .sweep_start(sweep_start), .sweep_done(sweep_done),
`endif
    .err_angle(err_angle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [1:0] quad; logic [TAG_W-1:0] tag; } exp_t;
  exp_t sbq[$];

  // Reference model state (spec-level: last accepted bin, sticky error flag)
  logic [8:0]       m_sel = 9'h001;
  logic [1:0]       m_quad = 2'd0;
  logic             m_err = 1'b0;
  logic             prev_stall = 1'b0;
  logic [1:0]       prev_quad = 2'd0;
  logic [TAG_W-1:0] prev_tag = '0;
  bit               sweep_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_bin(input int b);
    return (b >= 36) ? 0 : b;
  endfunction

  // Monitor/scoreboard: at each falling edge, outputs are settled and the
  // inputs are those the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      m_sel = 9'h001; m_quad = 2'd0; m_err = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("err_angle", 32'(err_angle), 32'(m_err));
      chk("rot_en", 32'(rot_en), 32'(!(out_valid && !out_ready)));
      if (!sweep_on) begin
        chk("rot_sel", 32'(rot_sel), 32'(m_sel));
        chk("rot_quad", 32'(rot_quad), 32'(m_quad));
        chk("busy", 32'(busy), 32'(sbq.size() != 0));
        chk("req_ready", 32'(req_ready), 32'(!(out_valid && !out_ready)));
      end else begin
        chk("sweep_req_blocked", 32'(req_valid && req_ready), 32'd0);
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_quad", 32'(out_quad), 32'(prev_quad));
        chk("stall_tag", 32'(out_tag), 32'(prev_tag));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got tag %0h expected no output at %0t", out_tag, $time);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_quad", 32'(out_quad), 32'(e.quad));
          chk("out_tag", 32'(out_tag), 32'(e.tag));
        end
      end
      if (!sweep_on && req_valid && req_ready) begin
        int b;
        b = ref_bin(int'(req_angle));
        sbq.push_back('{quad: 2'(b / 9), tag: req_tag});
        m_sel  = 9'(1) << (b % 9);
        m_quad = 2'(b / 9);
        if (req_angle >= 6'd36) m_err = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_quad  = out_quad;
      prev_tag   = out_tag;
    end
  end

  // Called at posedge+2; returns at the posedge+2 after the accepting edge.
  task automatic send(input logic [5:0] b, input logic [TAG_W-1:0] t);
    int n;
    req_valid = 1'b1; req_angle = b; req_tag = t;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: got req_ready 0 expected 1 at %0t", $time);
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    repeat (3) begin @(posedge clk); #2; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_rot_sel", 32'(rot_sel), 32'h001);
    chk("rst_rot_quad", 32'(rot_quad), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_quad", 32'(out_quad), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_angle), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #2; end

    // Single request: bin 23 -> quad 2, sub 5, latency PIPE_LAT
    out_ready = 1'b1;
    req_valid = 1'b1; req_angle = 6'd23; req_tag = 8'h5A;
    @(posedge clk); #2; req_valid = 1'b0;
    for (int k = 1; k <= PIPE_LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("single_rot_sel", 32'(rot_sel), 32'h020);
        chk("single_rot_quad", 32'(rot_quad), 32'd2);
      end
      chk("single_latency", 32'(out_valid), 32'(k == PIPE_LAT));
    end
    chk("single_out_quad", 32'(out_quad), 32'd2);
    chk("single_out_tag", 32'(out_tag), 32'h5A);
    @(posedge clk); #2;
    drain();

    // Stream bins 0..35 back-to-back
    for (int b = 0; b < 36; b++) send(6'(b), 8'(b));
    drain();

    // Backpressure: 5 cycles of out_ready=0 mid-stream
    fork
      for (int b = 0; b < 14; b++) send(6'(b * 2), 8'(8'h80 + b));
      begin
        repeat (5) begin @(posedge clk); #2; end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_rot_en", 32'(rot_en), 32'd0);
          chk("bp_req_ready", 32'(req_ready), 32'd0);
          @(posedge clk); #2;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Illegal bin 40 -> treated as bin 0, sticky error
    send(6'd40, 8'hE7);
    @(negedge clk);
    chk("illegal_rot_sel", 32'(rot_sel), 32'h001);
    chk("illegal_err", 32'(err_angle), 32'd1);
    @(posedge clk); #2;
    drain();
    send(6'd17, 8'h11);
    drain();
    chk("err_sticky", 32'(err_angle), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom % 10) < 7;
      req_angle = (($urandom % 8) == 0) ? 6'(36 + $urandom % 28) : 6'($urandom % 36);
      req_tag   = 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #2;
    end
    drain();

    // Reset with two entries in flight
    out_ready = 1'b0;
    send(6'd9, 8'hA1);
    send(6'd35, 8'hA2);
    @(posedge clk); #2;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_err", 32'(err_angle), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1; out_ready = 1'b1;
    repeat (8) begin @(posedge clk); #2; end   // monitor flags any output here

`ifdef WROT_SWEEP_EN
    begin
      int dn, n;
      sweep_on = 1'b1;
      for (int b = 0; b < 36; b++) sbq.push_back('{quad: 2'(b / 9), tag: 8'(b)});
      sweep_start = 1'b1; req_valid = 1'b1; req_angle = 6'd5; req_tag = 8'hCC;
      @(posedge clk); #2; sweep_start = 1'b0;
      repeat (3) begin @(posedge clk); #2; end
      req_valid = 1'b0;
      dn = 0; n = 0;
      while (dn == 0 && n < 2000) begin
        out_ready = ($urandom % 3) != 0;
        @(negedge clk);
        if (sweep_done) begin
          dn++;
          chk("sweep_all_out", 32'(sbq.size()), 32'd0);
        end
        @(posedge clk); #2;
        n++;
      end
      out_ready = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (sweep_done) dn++;
        @(posedge clk); #2;
      end
      chk("sweep_done_once", 32'(dn), 32'd1);
      m_sel = 9'h100; m_quad = 2'd3;
      sweep_on = 1'b0;
      send(6'd1, 8'h44);
      drain();
    end
`endif

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
